// File: rtl/cbp_qpd_seq.sv
// Macroblock coded_block_pattern / mb_qp_delta sequencer.
// Emits up to two Exp-Golomb codewords per macroblock over a valid/ready handshake.
module cbp_qpd_seq #(
    parameter bit EN_QPD = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  mb_type_i,
    input  logic [5:0]  cbp_i,
    input  logic [6:0]  qp_delta_i,
    input  logic        ready_i,
    output logic [10:0] code_o,
    output logic [3:0]  len_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned CODE_W = 11;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned CN_W   = 6;
    localparam int unsigned CBP_W  = 6;
    localparam int unsigned QP_W   = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CBP  = 2'd1;
    localparam logic [1:0] ST_QPD  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] MB_I4    = 2'd0;
    localparam logic [1:0] MB_I16   = 2'd1;
    localparam logic [1:0] MB_INTER = 2'd2;

    // cbp -> codeNum, element [cbp]; the literal lists cbp 47 first, cbp 0 last
    localparam logic [47:0][CN_W-1:0] INTRA_CN = {
        6'd0,  6'd15, 6'd14, 6'd28, 6'd13, 6'd27, 6'd47, 6'd45,
        6'd12, 6'd46, 6'd26, 6'd44, 6'd25, 6'd43, 6'd42, 6'd41,
        6'd1,  6'd7,  6'd6,  6'd24, 6'd5,  6'd23, 6'd40, 6'd36,
        6'd4,  6'd39, 6'd22, 6'd35, 6'd21, 6'd34, 6'd33, 6'd16,
        6'd2,  6'd11, 6'd10, 6'd20, 6'd9,  6'd19, 6'd38, 6'd32,
        6'd8,  6'd37, 6'd18, 6'd31, 6'd17, 6'd30, 6'd29, 6'd3
    };
    localparam logic [47:0][CN_W-1:0] INTER_CN = {
        6'd12, 6'd31, 6'd30, 6'd23, 6'd29, 6'd22, 6'd47, 6'd27,
        6'd28, 6'd46, 6'd21, 6'd26, 6'd20, 6'd25, 6'd24, 6'd6,
        6'd19, 6'd43, 6'd42, 6'd39, 6'd41, 6'd38, 6'd45, 6'd35,
        6'd40, 6'd44, 6'd37, 6'd34, 6'd36, 6'd33, 6'd32, 6'd1,
        6'd11, 6'd16, 6'd15, 6'd10, 6'd14, 6'd9,  6'd18, 6'd5,
        6'd13, 6'd17, 6'd8,  6'd4,  6'd7,  6'd3,  6'd2,  6'd0
    };

    function automatic logic need_cbp(input logic [1:0] t);
        return (t == MB_I4) || (t == MB_INTER);
    endfunction

    function automatic logic need_qpd(input logic [1:0] t, input logic [CBP_W-1:0] c);
        return EN_QPD && ((t == MB_I16) || (need_cbp(t) && (c != '0)));
    endfunction

    function automatic logic cbp_bad(input logic [CBP_W-1:0] c);
        return c > CBP_W'(47);
    endfunction

    function automatic logic [CN_W-1:0] cbp_cn(input logic [1:0] t, input logic [CBP_W-1:0] c);
        if (cbp_bad(c)) return '0;
        return (t == MB_I4) ? INTRA_CN[c] : INTER_CN[c];
    endfunction

    function automatic logic qpd_bad(input logic [QP_W-1:0] q);
        int k;
        k = int'($signed(q));
        return (k > 25) || (k < -26);
    endfunction

    // se(v) mapping after saturating to the legal delta range
    function automatic logic [CN_W-1:0] qpd_cn(input logic [QP_W-1:0] q);
        int k;
        k = int'($signed(q));
        if (k > 25)  k = 25;
        if (k < -26) k = -26;
        return (k > 0) ? CN_W'(2 * k - 1) : CN_W'(-2 * k);
    endfunction

    function automatic logic [LEN_W-1:0] ue_len(input logic [CN_W-1:0] cn);
        logic [CN_W:0] v;
        int m;
        v = {1'b0, cn} + (CN_W + 1)'(1);
        m = 0;
        for (int i = 0; i <= int'(CN_W); i++) begin
            if (v[i]) m = i;
        end
        return LEN_W'(2 * m + 1);
    endfunction

    logic [1:0]       state, state_nxt;
    logic [1:0]       mb_type_q;
    logic [CBP_W-1:0] cbp_q;
    logic [QP_W-1:0]  qp_q;
    logic             accept_c;
    logic             load_c;
    logic [CN_W-1:0]  cn_c;
    logic             err_set_c;

    assign accept_c = (state == ST_IDLE) && start_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and codeNum to load on entry to CBP/QPD
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        cn_c      = '0;
        err_set_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    if (need_cbp(mb_type_i)) begin
                        state_nxt = ST_CBP;
                        load_c    = 1'b1;
                        cn_c      = cbp_cn(mb_type_i, cbp_i);
                        err_set_c = cbp_bad(cbp_i);
                    end else if (need_qpd(mb_type_i, cbp_i)) begin
                        state_nxt = ST_QPD;
                        load_c    = 1'b1;
                        cn_c      = qpd_cn(qp_delta_i);
                        err_set_c = qpd_bad(qp_delta_i);
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_CBP: begin
                if (ready_i) begin
                    if (need_qpd(mb_type_q, cbp_q)) begin
                        state_nxt = ST_QPD;
                        load_c    = 1'b1;
                        cn_c      = qpd_cn(qp_q);
                        err_set_c = qpd_bad(qp_q);
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_QPD: begin
                if (ready_i) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Macroblock parameters captured only on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb_type_q <= '0;
            cbp_q     <= '0;
            qp_q      <= '0;
        end else if (accept_c) begin
            mb_type_q <= mb_type_i;
            cbp_q     <= cbp_i;
            qp_q      <= qp_delta_i;
        end
    end

    // Registered outputs, decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_o  <= '0;
            len_o   <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            valid_o <= (state_nxt == ST_CBP) || (state_nxt == ST_QPD);
            busy_o  <= (state_nxt != ST_IDLE);
            done_o  <= (state_nxt == ST_DONE);
            err_o   <= (accept_c ? 1'b0 : err_o) | err_set_c;
            if (load_c) begin
                code_o <= CODE_W'({1'b0, cn_c} + (CN_W + 1)'(1));
                len_o  <= ue_len(cn_c);
            end else if ((state_nxt == ST_DONE) || (state_nxt == ST_IDLE)) begin
                code_o <= '0;
                len_o  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cbp_qpd_seq.sv
// Directed plus randomized bench for cbp_qpd_seq with a codeword scoreboard.
module tb_cbp_qpd_seq;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  mb_type_i;
    logic [5:0]  cbp_i;
    logic [6:0]  qp_delta_i;
    logic        ready_i;
    logic [10:0] code_o;
    logic [3:0]  len_o;
    logic        valid_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    cbp_qpd_seq #(.EN_QPD(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .mb_type_i  (mb_type_i),
        .cbp_i      (cbp_i),
        .qp_delta_i (qp_delta_i),
        .ready_i    (ready_i),
        .code_o     (code_o),
        .len_o      (len_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // codeNum -> cbp, as listed in the CBP me(v) table
    int fwd_intra[48] = '{47,31,15,0,23,27,29,30,7,11,13,14,39,43,45,46,
                          16,3,5,10,12,19,21,26,28,35,37,42,44,1,2,4,
                          8,17,18,20,24,6,9,22,25,32,33,34,36,40,38,41};
    int fwd_inter[48] = '{0,16,1,2,4,8,32,3,5,10,12,15,47,7,11,13,
                          14,6,9,31,35,37,42,44,33,34,36,40,39,43,45,46,
                          17,18,20,24,19,21,26,28,23,27,29,30,22,25,38,41};

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           n_done = 0;
    int           done_at = -1;
    bit           exp_err;
    bit           stalled = 1'b0;
    logic [10:0]  hold_code;
    logic [3:0]   hold_len;
    logic [14:0]  exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_cbp_cn(input int t, input int c);
        if (c > 47) return 0;
        for (int n = 0; n < 48; n++) begin
            if (((t == 0) ? fwd_intra[n] : fwd_inter[n]) == c) return n;
        end
        return -1;
    endfunction

    task automatic push_cw(input int cn);
        int v;
        int len;
        v   = cn + 1;
        len = 2 * ($clog2(v + 1) - 1) + 1;
        exp_q.push_back({11'(v), 4'(len)});
    endtask

    task automatic push_exp(input int t, input int c, input logic [6:0] q);
        bit nc;
        bit nq;
        int k;
        nc = (t == 0) || (t == 2);
        nq = (t == 1) || (nc && (c != 0));
        k  = int'($signed(q));
        exp_err = 1'b0;
        if (nc) begin
            if (c > 47) exp_err = 1'b1;
            push_cw(model_cbp_cn(t, c));
        end
        if (nq) begin
            if (k > 25)  begin k = 25;  exp_err = 1'b1; end
            if (k < -26) begin k = -26; exp_err = 1'b1; end
            push_cw((k > 0) ? (2 * k - 1) : (-2 * k));
        end
    endtask

    // Sampled mid-cycle: scoreboard pops on transfers, hold checks on stalls
    task automatic monitor();
        logic [14:0] e;
        if (done_o) begin
            n_done++;
            done_at = cyc;
            chk("valid_in_done", 32'(valid_o), 32'd0);
        end
        if (stalled) begin
            chk("hold_valid", 32'(valid_o), 32'd1);
            chk("hold_code", 32'(code_o), 32'(hold_code));
            chk("hold_len", 32'(len_o), 32'(hold_len));
        end
        stalled   = valid_o && !ready_i;
        hold_code = code_o;
        hold_len  = len_o;
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cw", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("cw_code", 32'(code_o), 32'(e[14:4]));
                chk("cw_len", 32'(len_o), 32'(e[3:0]));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // stall<0: random ready; exp_lat<0: latency not checked
    task automatic do_mb(input logic [1:0] t, input logic [5:0] c, input logic [6:0] q,
                         input int stall, input int exp_lat);
        int s;
        int nexp;
        push_exp(int'(t), int'(c), q);
        nexp       = exp_q.size();
        mb_type_i  = t;
        cbp_i      = c;
        qp_delta_i = q;
        start_i    = 1'b1;
        ready_i    = (stall == 0);
        s          = cyc;
        n_done     = 0;
        done_at    = -1;
        tick();
        chk("busy_c1", 32'(busy_o), 32'd1);
        chk("valid_c1", 32'(valid_o), 32'(nexp > 0));
        start_i    = 1'b0;
        mb_type_i  = 2'($urandom);
        cbp_i      = 6'($urandom);
        qp_delta_i = 7'($urandom);
        for (int i = 0; i < 60 && n_done == 0; i++) begin
            if (stall < 0) ready_i = 1'($urandom);
            else           ready_i = (i >= stall);
            start_i = (stall > 0) && (i == 1);
            tick();
        end
        start_i = 1'b0;
        ready_i = 1'b0;
        chk("done_seen", 32'(n_done), 32'd1);
        if (exp_lat >= 0) chk("done_latency", 32'(done_at - s), 32'(exp_lat));
        chk("err_flag", 32'(err_o), 32'(exp_err));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("busy_idle", 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start_i    = 1'b0;
        ready_i    = 1'b0;
        mb_type_i  = '0;
        cbp_i      = '0;
        qp_delta_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_code", 32'(code_o), 32'd0);
        chk("rst_len", 32'(len_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst_n = 1'b1;

        do_mb(2'd0, 6'd0,  7'd5,          0, 2);   // I4x4 cbp 0: CBP only
        do_mb(2'd2, 6'd15, 7'(-2),        0, 3);   // inter: codeNum 11 then 4
        do_mb(2'd1, 6'd13, 7'd0,          0, 2);   // I16x16: qp_delta 0
        do_mb(2'd0, 6'd47, 7'd3,          0, 3);   // I4x4 cbp 47 -> codeNum 0
        do_mb(2'd3, 6'd9,  7'd7,          0, 1);   // skip
        do_mb(2'd2, 6'd50, 7'd1,          0, 3);   // bad cbp
        do_mb(2'd1, 6'd0,  7'd40,         0, 2);   // qp_delta saturates high
        do_mb(2'd1, 6'd0,  7'(-30),       0, 2);   // qp_delta saturates low
        do_mb(2'd1, 6'd0,  7'(-26),       0, 2);   // legal extremes
        do_mb(2'd1, 6'd0,  7'd25,         0, 2);
        do_mb(2'd2, 6'd6,  7'd0,          4, 7);   // stall with stray start

        for (int n = 0; n < 24; n++) begin
            do_mb(2'($urandom_range(0, 3)), 6'($urandom_range(0, 50)),
                  7'($urandom_range(0, 127)), -1, -1);
        end

        // Reset while a QPD codeword is pending
        push_exp(2, 15, 7'(-2));
        mb_type_i  = 2'd2;
        cbp_i      = 6'd15;
        qp_delta_i = 7'(-2);
        start_i    = 1'b1;
        ready_i    = 1'b0;
        tick();
        start_i = 1'b0;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        tick();
        chk("qpd_pending_valid", 32'(valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_code", 32'(code_o), 32'd0);
        chk("arst_len", 32'(len_o), 32'd0);
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        chk("arst_err", 32'(err_o), 32'd0);
        exp_q.delete();
        stalled = 1'b0;
        n_done  = 0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("no_done_after_abort", 32'(n_done), 32'd0);
        do_mb(2'd2, 6'd15, 7'(-2), 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
